ahb2_sram_slv: RTL and testbench
================================

// Module: ahb2_sram_slv
// PURPOSE
//  AHB2 slave terminating one AHB2_SLV_INTF port (downstream of the bus decoder/mux).
//  Holds a 32-bit-wide register-array memory. Serves byte/halfword/word reads and writes
//  with programmable wait states and the AMBA2 two-cycle ERROR response for illegal
//  transfers. Never issues RETRY or SPLIT.
// PARAMETERS
//  DEPTH_LOG2   8   memory depth = 2**DEPTH_LOG2 words; word index = haddr[DEPTH_LOG2+1:2]
//  WAIT_STATES  0   hreadyo-low cycles per OKAY data phase, 0..7
// PORTS
//  hclk     in   1   bus clock, all state on rising edge
//  hreset   in   1   reset, async, active-high
//  hsel     in   1   slave select from decoder
//  haddr    in   32  address; bits above DEPTH_LOG2+1 ignored (aliasing)
//  htrans   in   2   IDLE/BUSY/NONSEQ/SEQ
//  hwrite   in   1   1=write
//  hsize    in   3   transfer size
//  hburst   in   3   ignored; each beat handled independently
//  hprot    in   4   ignored
//  hwdata   in   32  write data, data phase
//  hreadyi  in   1   bus-level HREADY (previous transfer complete)
//  hrdata   out  32  read data
//  hreadyo  out  1   this slave's HREADY
//  hresp    out  2   OKAY or ERROR only
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: hreadyo=1, hresp=OKAY, hrdata=0, FSM=IDLE. Memory not reset (contents undefined).
//  Accept = hsel & hreadyi & htrans[1] (NONSEQ/SEQ): latch addr, hsize, hwrite, err flag.
//  IDLE/BUSY or hsel=0 with hreadyi=1 -> zero-wait OKAY, no memory access.
//  err = hsize>HSIZE_32BITS | (hsize==16b & haddr[0]) | (hsize==32b & haddr[1:0]!=0).
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE: accept & err -> ERR1; accept & WAIT_STATES==0 -> DATA; accept -> WAIT (cnt=WAIT_STATES-1).
//   WAIT: hreadyo=0, hresp=OKAY; cnt==0 -> DATA else cnt--.
//   DATA: hreadyo=1, hresp=OKAY; transfer completes; new accept evaluated same cycle
//         (same branch rules as IDLE), else -> IDLE.
//   ERR1: hreadyo=0, hresp=ERROR -> ERR2.  ERR2: hreadyo=1, hresp=ERROR; accept -> as IDLE.
//  Latency: OKAY data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
//  Write: hwdata sampled in DATA cycle; memory updated at edge ending it. Little-endian
//   lanes: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0}+1:0; word -> all.
//   Non-selected bytes unchanged. Errored transfers never write.
//  Read: hrdata = full 32-bit word at latched index, valid only in DATA of a read; 0 in
//   every other cycle. Read accepted during a write's DATA cycle to the same word returns
//   the newly written data (array updated before read data phase).
//  hsel/htrans changes during WAIT/ERR1 do not abort the committed data phase.
//  hreset mid-transfer: immediate return to reset values; pending write discarded.
// TESTING
//  WAIT_STATES=0: write word 0xDEADBEEF @0x10, read @0x10 -> hrdata 0xDEADBEEF, hreadyo never low.
//  WAIT_STATES=3: read @0x20 -> hreadyo low exactly 3 cycles, then 1 with OKAY and data.
//  Byte write 0xAA to 0x13 over word 0x11223344 @0x10 -> read 0xAA223344.
//  Halfword @0x11 and word @0x22 -> ERR1/ERR2 (hreadyo 0 then 1, hresp ERROR), memory unchanged.
//  Back-to-back NONSEQ write 0x55 @0x30 then read @0x30 pipelined -> read returns 0x55.
//  Assert hreset during WAIT -> hreadyo=1, hresp=OKAY, hrdata=0 same cycle; no write committed.

Source files
------------

// File: rtl/ahb2_sram_slv_if.sv
// AHB2 slave-port bundle: address/control, write data and the slave response signals.
interface ahb2_sram_slv_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyi;
  logic [31:0] hrdata;
  logic        hreadyo;
  logic [1:0]  hresp;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    output hrdata, hreadyo, hresp
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    input  hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_sram_slv.sv
// AHB2 SRAM slave: 32-bit register-array memory with byte/halfword/word access,
// programmable wait states and the two-cycle ERROR response for illegal transfers.
module ahb2_sram_slv #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb2_sram_slv_if.slave slv
);

  localparam int unsigned Words     = 2 ** DEPTH_LOG2;
  localparam int unsigned AddrW     = DEPTH_LOG2 + 2;
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespError = 2'b01;
  localparam logic [2:0]  CntInit   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e             r_state;
  logic [2:0]         r_cnt;
  logic [AddrW-1:0]   r_addr;
  logic [1:0]         r_size;
  logic               r_write;
  logic               r_hreadyo;
  logic [1:0]         r_hresp;
  logic [31:0]        r_hrdata;
  logic [31:0]        r_mem [Words];

  logic                  w_accept;
  logic                  w_err;
  logic                  w_wr_en;
  logic [3:0]            w_strb;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic [DEPTH_LOG2-1:0] w_new_idx;
  logic [31:0]           w_wr_word;
  logic [31:0]           w_rd_new;
  state_e                w_l_state;
  logic                  w_l_rdy;
  logic [1:0]            w_l_resp;
  logic [31:0]           w_l_data;
  logic                  w_unused_bits;

  // Upper address bits alias; burst and protection info carry no meaning here.
  assign w_unused_bits = ^{slv.haddr[31:AddrW], slv.hburst, slv.hprot};

  assign w_accept  = slv.hsel & slv.hreadyi & slv.htrans[1];
  assign w_err     = (slv.hsize > 3'd2)
                   | ((slv.hsize == 3'd1) & slv.haddr[0])
                   | ((slv.hsize == 3'd2) & (slv.haddr[1:0] != 2'b00));
  assign w_cur_idx = r_addr[AddrW-1:2];
  assign w_new_idx = slv.haddr[AddrW-1:2];
  assign w_wr_en   = (r_state == StData) & r_write;

  // Byte-lane strobes of the transfer currently in its data phase.
  always_comb begin
    w_strb = 4'b0000;
    case (r_size)
      2'd0:    w_strb = 4'b0001 << r_addr[1:0];
      2'd1:    w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  // Merge write data into the stored word; forward it to a read launched this cycle.
  always_comb begin
    w_wr_word = r_mem[w_cur_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_strb[b]) w_wr_word[8*b +: 8] = slv.hwdata[8*b +: 8];
    end
    w_rd_new = (w_wr_en && (w_new_idx == w_cur_idx)) ? w_wr_word : r_mem[w_new_idx];
  end

  // Next state/outputs when a new address phase may be taken (IDLE, DATA, ERR2).
  always_comb begin
    w_l_state = StIdle;
    w_l_rdy   = 1'b1;
    w_l_resp  = RespOkay;
    w_l_data  = 32'h0;
    if (w_accept) begin
      if (w_err) begin
        w_l_state = StErr1;
        w_l_rdy   = 1'b0;
        w_l_resp  = RespError;
      end else if (WAIT_STATES == 0) begin
        w_l_state = StData;
        w_l_data  = slv.hwrite ? 32'h0 : w_rd_new;
      end else begin
        w_l_state = StWait;
        w_l_rdy   = 1'b0;
      end
    end
  end

  // Transfer FSM with registered bus outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_addr    <= '0;
      r_size    <= 2'd0;
      r_write   <= 1'b0;
      r_hreadyo <= 1'b1;
      r_hresp   <= RespOkay;
      r_hrdata  <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle, StData, StErr2: begin
          r_state   <= w_l_state;
          r_hreadyo <= w_l_rdy;
          r_hresp   <= w_l_resp;
          r_hrdata  <= w_l_data;
          if (w_accept) begin
            r_addr  <= slv.haddr[AddrW-1:0];
            r_size  <= slv.hsize[1:0];
            r_write <= slv.hwrite;
            r_cnt   <= CntInit;
          end
        end
        StWait: begin
          if (r_cnt == 3'd0) begin
            r_state   <= StData;
            r_hreadyo <= 1'b1;
            r_hresp   <= RespOkay;
            r_hrdata  <= r_write ? 32'h0 : r_mem[w_cur_idx];
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        StErr1: begin
          r_state   <= StErr2;
          r_hreadyo <= 1'b1;
          r_hresp   <= RespError;
          r_hrdata  <= 32'h0;
        end
        default: begin
          r_state   <= StIdle;
          r_hreadyo <= 1'b1;
          r_hresp   <= RespOkay;
          r_hrdata  <= 32'h0;
        end
      endcase
    end
  end

  // Memory commit at the edge ending a write data phase; never reset.
  always_ff @(posedge hclk) begin
    if (w_wr_en && !hreset) r_mem[w_cur_idx] <= w_wr_word;
  end

  assign slv.hreadyo = r_hreadyo;
  assign slv.hresp   = r_hresp;
  assign slv.hrdata  = r_hrdata;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Bench for ahb2_sram_slv: two instances (0 and 3 wait states) on one clock, driven as a
// pipelined AHB master and checked cycle by cycle against a transaction-level model.
module tb_ahb2_sram_slv;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrNseq = 2'b10;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  bit          cur;
  logic        d_sel;
  logic [1:0]  d_trans;
  logic        d_wr;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_burst;
  logic [3:0]  d_prot;
  logic        obs_rdy;
  logic [1:0]  obs_resp;
  logic [31:0] obs_data;

  int          n_assert = 0;
  int          n_fail   = 0;
  item_t       items[$];
  exp_t        exp_q[$];
  logic [31:0] mdl [2][256];

  ahb2_sram_slv_if bus0 ();
  ahb2_sram_slv_if bus1 ();

  ahb2_sram_slv #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .slv(bus0.slave)
  );
  ahb2_sram_slv #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .slv(bus1.slave)
  );

  always #5 hclk = ~hclk;

  assign obs_rdy  = cur ? bus1.hreadyo : bus0.hreadyo;
  assign obs_resp = cur ? bus1.hresp   : bus0.hresp;
  assign obs_data = cur ? bus1.hrdata  : bus0.hrdata;

  assign bus0.hsel    = d_sel & ~cur;
  assign bus1.hsel    = d_sel & cur;
  assign bus0.haddr   = d_addr;
  assign bus1.haddr   = d_addr;
  assign bus0.htrans  = d_trans;
  assign bus1.htrans  = d_trans;
  assign bus0.hwrite  = d_wr;
  assign bus1.hwrite  = d_wr;
  assign bus0.hsize   = d_size;
  assign bus1.hsize   = d_size;
  assign bus0.hburst  = d_burst;
  assign bus1.hburst  = d_burst;
  assign bus0.hprot   = d_prot;
  assign bus1.hprot   = d_prot;
  assign bus0.hwdata  = d_wdata;
  assign bus1.hwdata  = d_wdata;
  assign bus0.hreadyi = obs_rdy;
  assign bus1.hreadyi = obs_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Queue one address phase and append its data-phase cycles to the expected stream.
  task automatic add_item(input bit sel, input logic [1:0] trans, input bit wr,
                          input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
    item_t it;
    exp_t  e;
    int    nb;
    int    off;
    int    idx;
    int    ws;
    it.sel = sel; it.trans = trans; it.wr = wr;
    it.size = size; it.addr = addr; it.wdata = wdata;
    items.push_back(it);
    ws = cur ? 3 : 0;
    if (!(sel && trans[1])) begin
      e = '{rdy: 1'b1, resp: 2'b00, data: 32'h0};
      exp_q.push_back(e);
      return;
    end
    off = int'(addr % 4);
    idx = int'((addr / 4) % 256);
    nb  = (size <= 3'd2) ? (1 << size) : 0;
    if (nb == 0 || (off % nb) != 0) begin
      e = '{rdy: 1'b0, resp: 2'b01, data: 32'h0};
      exp_q.push_back(e);
      e = '{rdy: 1'b1, resp: 2'b01, data: 32'h0};
      exp_q.push_back(e);
      return;
    end
    for (int w = 0; w < ws; w++) begin
      e = '{rdy: 1'b0, resp: 2'b00, data: 32'h0};
      exp_q.push_back(e);
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + nb) mdl[cur][idx][8*b +: 8] = wdata[8*b +: 8];
      end
      e = '{rdy: 1'b1, resp: 2'b00, data: 32'h0};
    end else begin
      e = '{rdy: 1'b1, resp: 2'b00, data: mdl[cur][idx]};
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_addr(input int i);
    if (i < items.size()) begin
      d_sel = items[i].sel; d_trans = items[i].trans; d_wr = items[i].wr;
      d_size = items[i].size; d_addr = items[i].addr;
    end else begin
      d_sel = 1'b0; d_trans = TrIdle; d_wr = 1'b0; d_size = 3'd0; d_addr = 32'h0;
    end
    d_burst = 3'($urandom_range(0, 7));
    d_prot  = 4'($urandom_range(0, 15));
  endtask

  // Play the queued items back-to-back; must be entered at a negedge with the bus idle.
  task automatic run_items();
    int  ai = 0;
    bit  prev_rdy = 1'b1;
    int  n;
    add_item(1'b0, TrIdle, 1'b0, 3'd0, 32'h0, 32'h0);
    n = exp_q.size();
    drive_addr(0);
    for (int c = 0; c < n; c++) begin
      @(negedge hclk);
      if (prev_rdy) begin
        d_wdata = (ai < items.size()) ? items[ai].wdata : 32'h0;
        ai++;
        drive_addr(ai);
      end
      check($sformatf("dut%0d cyc%0d hreadyo", cur, c), 32'(obs_rdy), 32'(exp_q[c].rdy));
      check($sformatf("dut%0d cyc%0d hresp", cur, c), 32'(obs_resp), 32'(exp_q[c].resp));
      check($sformatf("dut%0d cyc%0d hrdata", cur, c), obs_data, exp_q[c].data);
      prev_rdy = obs_rdy;
    end
    items.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    hreset = 1'b1;
    cur = 1'b0;
    d_sel = 1'b0; d_trans = TrIdle; d_wr = 1'b0; d_size = 3'd0;
    d_addr = 32'h0; d_wdata = 32'h0; d_burst = 3'd0; d_prot = 4'd0;

    // Reset values of both instances.
    @(negedge hclk);
    check("reset dut0 hreadyo", 32'(bus0.hreadyo), 32'd1);
    check("reset dut0 hresp", 32'(bus0.hresp), 32'd0);
    check("reset dut0 hrdata", bus0.hrdata, 32'h0);
    check("reset dut1 hreadyo", 32'(bus1.hreadyo), 32'd1);
    check("reset dut1 hresp", 32'(bus1.hresp), 32'd0);
    check("reset dut1 hrdata", bus1.hrdata, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      cur = (d == 1);
      // Fill the working region so every later read has defined contents.
      for (int i = 0; i < 32; i++) add_item(1'b1, TrNseq, 1'b1, 3'd2, 32'(i * 4), $urandom());
      run_items();
      // Word write then read back.
      add_item(1'b1, TrNseq, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h10, 32'h0);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h20, 32'h0);
      run_items();
      // Byte lane 3 merge over an existing word.
      add_item(1'b1, TrNseq, 1'b1, 3'd2, 32'h10, 32'h11223344);
      add_item(1'b1, TrNseq, 1'b1, 3'd0, 32'h13, 32'hAA000000);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h10, 32'h0);
      run_items();
      // Misaligned halfword and word: ERROR, memory left alone.
      add_item(1'b1, TrNseq, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF);
      add_item(1'b1, TrNseq, 1'b1, 3'd2, 32'h22, 32'hFFFFFFFF);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h10, 32'h0);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h20, 32'h0);
      run_items();
      // Pipelined write then read of the same word.
      add_item(1'b1, TrNseq, 1'b1, 3'd2, 32'h30, 32'h00000055);
      add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h30, 32'h0);
      run_items();
      // Randomised mix: sizes, alignment, idle/busy, deselect, aliased upper address bits.
      for (int i = 0; i < 80; i++) begin
        a = $urandom();
        a[9:2] = 8'($urandom_range(0, 31));
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'((1 << sz) - 1);
        tr = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) tr[1] = 1'b1;
        add_item($urandom_range(0, 7) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom());
      end
      run_items();
    end

    // Reset during a read data phase (no wait states): outputs drop at once.
    cur = 1'b0;
    d_sel = 1'b1; d_trans = TrNseq; d_wr = 1'b0; d_size = 3'd2; d_addr = 32'h10;
    @(negedge hclk);
    d_sel = 1'b0; d_trans = TrIdle;
    check("rstdata pre hrdata", obs_data, mdl[0][4]);
    #2 hreset = 1'b1;
    #1;
    check("rstdata hreadyo", 32'(obs_rdy), 32'd1);
    check("rstdata hresp", 32'(obs_resp), 32'd0);
    check("rstdata hrdata", obs_data, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;

    // Reset during ERR1.
    d_sel = 1'b1; d_trans = TrNseq; d_wr = 1'b1; d_size = 3'd2; d_addr = 32'h22;
    @(negedge hclk);
    d_sel = 1'b0; d_trans = TrIdle;
    check("rsterr pre hresp", 32'(obs_resp), 32'd1);
    #2 hreset = 1'b1;
    #1;
    check("rsterr hreadyo", 32'(obs_rdy), 32'd1);
    check("rsterr hresp", 32'(obs_resp), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;

    // Reset during a write's WAIT: the write must be discarded.
    cur = 1'b1;
    d_sel = 1'b1; d_trans = TrNseq; d_wr = 1'b1; d_size = 3'd2; d_addr = 32'h40;
    @(negedge hclk);
    d_wdata = 32'hCAFEF00D;
    d_sel = 1'b0; d_trans = TrIdle;
    check("rstwait pre hreadyo", 32'(obs_rdy), 32'd0);
    #2 hreset = 1'b1;
    #1;
    check("rstwait hreadyo", 32'(obs_rdy), 32'd1);
    check("rstwait hresp", 32'(obs_resp), 32'd0);
    check("rstwait hrdata", obs_data, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;
    add_item(1'b1, TrNseq, 1'b0, 3'd2, 32'h40, 32'h0);
    run_items();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
